// File: rtl/prng_pkg.sv
// prng_pkg: shared defaults, action encoding and width-agnostic LFSR helpers for prng_multi.
package prng_pkg;
    localparam int MAX_W = 64;
    localparam logic [15:0] DEFAULT_TAPS = 16'hB400;
    localparam logic [31:0] DEFAULT_FILLS = {16'hBEEF, 16'hDEAD};
    typedef logic [MAX_W-1:0] lfsr_t;
    typedef enum logic [1:0] {ACT_HOLD, ACT_STEP, ACT_RERUN, ACT_LOAD} act_e;
    // Operands are zero-extended to MAX_W so one function serves every LFSR width.
    function automatic lfsr_t lfsr_next(lfsr_t state, lfsr_t taps);
        return state[0] ? (state >> 1) ^ taps : state >> 1;
    endfunction
    function automatic lfsr_t lfsr_fix_zero(lfsr_t seed, lfsr_t fallback);
        return seed == '0 ? fallback : seed;
    endfunction
endpackage

// File: rtl/prng_multi_if.sv
// prng_multi_if: game-FSM controls and symbol outputs of prng_multi.
// seed_load/seed_in exist only when PRNG_SEED_LOAD_EN is defined.
interface prng_multi_if #(
    parameter int CHANNELS = 2,
    parameter int LOOKAHEAD = 3,
    parameter int POS_W = 8
`ifdef PRNG_SEED_LOAD_EN
    , parameter int LFSR_W = 16
`endif
);
    logic step;
    logic rerun;
    logic randomize;
    logic [CHANNELS-1:0] random;
    logic [LOOKAHEAD*CHANNELS-1:0] next_random;
    logic [POS_W-1:0] position;
`ifdef PRNG_SEED_LOAD_EN
    logic seed_load;
    logic [CHANNELS*LFSR_W-1:0] seed_in;
    modport master(output step, rerun, randomize, seed_load, seed_in, input random, next_random, position);
    modport slave(input step, rerun, randomize, seed_load, seed_in, output random, next_random, position);
`else
    modport master(output step, rerun, randomize, input random, next_random, position);
    modport slave(input step, rerun, randomize, output random, next_random, position);
`endif
endinterface

// File: rtl/prng_lfsr_chan.sv
// prng_lfsr_chan: one Galois LFSR channel with a saved start state and combinational lookahead.
module prng_lfsr_chan import prng_pkg::*; #(
    parameter int LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS = DEFAULT_TAPS,
    parameter logic [LFSR_W-1:0] FILL = DEFAULT_FILLS[15:0],
    parameter int LOOKAHEAD = 3
) (
    input  logic clk,
    input  logic reset,
    input  act_e act,
    input  logic [LFSR_W-1:0] seed,
    output logic lsb,
    output logic [LOOKAHEAD-1:0] look
);
    logic [LFSR_W-1:0] state_q, state_d, start_q, start_d, la;

    function automatic logic [LFSR_W-1:0] nxt(logic [LFSR_W-1:0] s);
        return LFSR_W'(lfsr_next(lfsr_t'(s), lfsr_t'(TAPS)));
    endfunction

    always_comb begin
        state_d = act == ACT_LOAD ? seed : act == ACT_RERUN ? start_q : act == ACT_STEP ? nxt(state_q) : state_q;
        start_d = act == ACT_LOAD ? seed : start_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FILL;
            start_q <= FILL;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
        end
    end

    always_comb begin
        la = state_q;
        look = '0;
        for (int k = 0; k < LOOKAHEAD; k++) begin
            la = nxt(la);
            look[k] = la[0];
        end
    end

    assign lsb = state_q[0];
endmodule

// File: rtl/prng_multi.sv
// prng_multi: multi-channel Galois LFSR symbol generator with replay, lookahead, entropy reseed and position count.
// Define PRNG_SEED_LOAD_EN to add the top-priority seed_load/seed_in direct seeding ports.
module prng_multi import prng_pkg::*; #(
    parameter int CHANNELS = 2,
    parameter int LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS = DEFAULT_TAPS,
    parameter logic [CHANNELS*LFSR_W-1:0] FILLS = DEFAULT_FILLS,
    parameter int LOOKAHEAD = 3,
    parameter int POS_W = 8
) (
    input logic clk,
    input logic reset,
    prng_multi_if.slave bus
);
    logic [LFSR_W-1:0] entropy_q, entropy_d;
    logic [POS_W-1:0] position_q, position_d;
    logic ext_load;
    logic [CHANNELS*LFSR_W-1:0] ext_seed;
    act_e act;
    logic [CHANNELS-1:0] lsb;
    logic [LOOKAHEAD-1:0] look [CHANNELS];

`ifdef PRNG_SEED_LOAD_EN
    assign ext_load = bus.seed_load;
    assign ext_seed = bus.seed_in;
`else
    assign ext_load = 1'b0;
    assign ext_seed = '0;
`endif

    always_comb begin
        act = ext_load || bus.randomize ? ACT_LOAD : bus.rerun ? ACT_RERUN : bus.step ? ACT_STEP : ACT_HOLD;
        entropy_d = entropy_q + 1'b1;
        position_d = act == ACT_HOLD ? position_q : act != ACT_STEP ? '0 : &position_q ? position_q : position_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entropy_q <= '0;
            position_q <= '0;
        end else begin
            entropy_q <= entropy_d;
            position_q <= position_d;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        localparam logic [LFSR_W-1:0] FILL = LFSR_W'(lfsr_fix_zero(lfsr_t'(FILLS[i*LFSR_W +: LFSR_W]), lfsr_t'(1)));
        localparam int ROT = i * (LFSR_W / CHANNELS);
        logic [LFSR_W-1:0] mixed, seed;
        // Each channel sees the entropy rotated differently so channels do not reseed in lockstep.
        always_comb begin
            mixed = FILL ^ ((entropy_q << ROT) | (entropy_q >> (LFSR_W - ROT)));
            seed = ext_load ? LFSR_W'(lfsr_fix_zero(lfsr_t'(ext_seed[i*LFSR_W +: LFSR_W]), lfsr_t'(FILL)))
                            : LFSR_W'(lfsr_fix_zero(lfsr_t'(mixed), lfsr_t'(FILL)));
        end
        prng_lfsr_chan #(
            .LFSR_W(LFSR_W),
            .TAPS(TAPS),
            .FILL(FILL),
            .LOOKAHEAD(LOOKAHEAD)
        ) u_chan (
            .clk(clk),
            .reset(reset),
            .act(act),
            .seed(seed),
            .lsb(lsb[i]),
            .look(look[i])
        );
    end

    always_comb begin
        bus.random = lsb;
        bus.next_random = '0;
        for (int k = 0; k < LOOKAHEAD; k++)
            for (int c = 0; c < CHANNELS; c++)
                bus.next_random[k*CHANNELS+c] = look[c][k];
    end

    assign bus.position = position_q;
endmodule

// File: tb/tb_prng_multi.sv
// tb_prng_multi: scoreboard bench for prng_multi; a per-clock reference model queues expected outputs, a monitor checks them.
module tb_prng_multi;
    localparam logic [15:0] TAPS = 16'hB400;
    localparam logic [15:0] FILL [2] = '{16'hDEAD, 16'hBEEF};

    typedef struct packed {
        logic [1:0] r;
        logic [5:0] nr;
        logic [7:0] pos;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int errors = 0;
    int mon_n = 0;
    exp_t exp_q[$];

    logic [15:0] st [2];
    logic [15:0] sv [2];
    int pos;
    logic [15:0] ent;

    prng_multi_if #(
        .CHANNELS(2),
        .LOOKAHEAD(3),
        .POS_W(8)
`ifdef PRNG_SEED_LOAD_EN
        , .LFSR_W(16)
`endif
    ) bus ();

    prng_multi dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] adv(logic [15:0] s);
        return s[0] ? (s >> 1) ^ TAPS : s >> 1;
    endfunction

    function automatic logic [15:0] rotl(logic [15:0] v, int r);
        return r == 0 ? v : (v << r) | (v >> (16 - r));
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        logic [15:0] a, b;
        a = st[0];
        b = st[1];
        e.r = {b[0], a[0]};
        e.nr = '0;
        for (int k = 0; k < 3; k++) begin
            a = adv(a);
            b = adv(b);
            e.nr[k*2 +: 2] = {b[0], a[0]};
        end
        e.pos = 8'(pos);
        return e;
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, x, $time);
        end
    endtask

    task automatic model_tick();
        logic [15:0] seed;
        if (!reset) begin
            st = FILL;
            sv = FILL;
            pos = 0;
            ent = '0;
            exp_q.delete();
        end else begin
`ifdef PRNG_SEED_LOAD_EN
            if (bus.seed_load) begin
                for (int i = 0; i < 2; i++) begin
                    seed = bus.seed_in[i*16 +: 16];
                    if (seed == 0) seed = FILL[i];
                    st[i] = seed;
                    sv[i] = seed;
                end
                pos = 0;
            end else
`endif
            if (bus.randomize) begin
                for (int i = 0; i < 2; i++) begin
                    seed = FILL[i] ^ rotl(ent, i * 8);
                    if (seed == 0) seed = FILL[i];
                    st[i] = seed;
                    sv[i] = seed;
                end
                pos = 0;
            end else if (bus.rerun) begin
                st = sv;
                pos = 0;
            end else if (bus.step) begin
                st[0] = adv(st[0]);
                st[1] = adv(st[1]);
                pos = pos == 255 ? 255 : pos + 1;
            end
            ent = ent + 16'd1;
        end
        exp_q.push_back(expect_now());
    endtask

    always @(posedge clk or negedge reset) model_tick();

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            mon_n++;
            chk("sb_random", 32'(bus.random), 32'(e.r));
            chk("sb_next_random", 32'(bus.next_random), 32'(e.nr));
            chk("sb_position", 32'(bus.position), 32'(e.pos));
        end
    end

    task automatic drive(input logic s, input logic r, input logic z);
        bus.step = s;
        bus.rerun = r;
        bus.randomize = z;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] t0, t1;
        bus.step = 1'b0;
        bus.rerun = 1'b0;
        bus.randomize = 1'b0;
`ifdef PRNG_SEED_LOAD_EN
        bus.seed_load = 1'b0;
        bus.seed_in = '0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        chk("reset_random", 32'(bus.random), 32'h3);
        chk("reset_next0", 32'(bus.next_random[1:0]), 32'h2);
        chk("reset_position", 32'(bus.position), 32'h0);

        drive(1, 0, 0);
        chk("step1_random", 32'(bus.random), 32'h2);
        chk("step1_position", 32'(bus.position), 32'h1);
        drive(0, 1, 0);
        chk("rerun_position", 32'(bus.position), 32'h0);

        for (int p = 0; p < 2; p++) begin
            t0 = FILL[0];
            t1 = FILL[1];
            for (int j = 0; j < 10; j++) begin
                drive(1, 0, 0);
                t0 = adv(t0);
                t1 = adv(t1);
                chk("trace_symbol", 32'(bus.random), 32'({t1[0], t0[0]}));
            end
            chk("trace_position", 32'(bus.position), 32'd10);
            drive(0, 1, 0);
            chk("trace_rerun_pos", 32'(bus.position), 32'd0);
        end

        repeat (3) drive(0, 0, 0);
        drive(1, 1, 1);
        chk("randomize_wins_pos", 32'(bus.position), 32'd0);
        repeat (5) drive(1, 0, 0);
        drive(0, 1, 0);
        drive(0, 0, 0);

        for (int j = 0; j < 200; j++)
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 31) == 0));

        drive(0, 1, 0);
        repeat (300) drive(1, 0, 0);
        chk("saturate_position", 32'(bus.position), 32'd255);

        repeat (4) drive(1, 0, 0);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_random", 32'(bus.random), 32'h3);
        chk("async_reset_position", 32'(bus.position), 32'h0);
        chk("async_reset_next0", 32'(bus.next_random[1:0]), 32'h2);
        @(negedge clk);
        #1 reset = 1'b1;
        repeat (3) drive(1, 0, 0);

`ifdef PRNG_SEED_LOAD_EN
        bus.seed_load = 1'b1;
        bus.seed_in = '0;
        drive(1, 0, 1);
        bus.seed_load = 1'b0;
        chk("seedload_zero_random", 32'(bus.random), 32'h3);
        chk("seedload_zero_pos", 32'(bus.position), 32'h0);
        for (int j = 0; j < 4; j++) begin
            bus.seed_load = 1'b1;
            bus.seed_in = $urandom;
            drive(0, 0, 0);
            bus.seed_load = 1'b0;
            repeat (5) drive(1, 0, 0);
            drive(0, 1, 0);
        end
`endif

        repeat (2) drive(0, 0, 0);
        chk("scoreboard_active", 32'(mon_n > 100), 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
